// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_arbiter
// Purpose  : Two-port round-robin arbiter and write-only bus sequencer for an
//            HD44780-style character LCD. Each accepted byte is driven through
//            setup, enable pulse, hold and execution-wait phases.
// Options  : define LCD_ARB_INIT_EN to add a power-on wait followed by the
//            built-in initialisation sequence before requesters are served.
// Revision : 1.0  initial release
// ============================================================================
module lcd_write_arbiter #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_CYC       = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POR_CYC        = 750000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_CYC), max_of(HOLD_CYC, WAIT_CYC)),
                                  max_of(CLEAR_WAIT_CYC, POR_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC);
  localparam cnt_t EN_LD    = cnt_t'(EN_CYC);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC);
  localparam cnt_t WAIT_LD  = cnt_t'(WAIT_CYC);
  localparam cnt_t CLEAR_LD = cnt_t'(CLEAR_WAIT_CYC);
  localparam cnt_t ONE      = cnt_t'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
`ifdef LCD_ARB_INIT_EN
    ST_WAIT  = 3'd4,
    ST_POR   = 3'd5,
    ST_INIT  = 3'd6
`else
    ST_WAIT  = 3'd4
`endif
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       ptr_q, ptr_d;        // 1: port 1 has priority on contention
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_en_q, lcd_en_d;

`ifdef LCD_ARB_INIT_EN
  localparam cnt_t POR_LD    = cnt_t'(POR_CYC);
  localparam logic [2:0] INIT_LEN = 3'd6;
  logic [2:0] init_idx_q, init_idx_d;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;  // function set, repeated for reliable wake-up
      3'd3:             return 8'h0C;  // display on, cursor off
      3'd4:             return 8'h01;  // clear display
      default:          return 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction
`endif

  // Round-robin grant: a lone valid port wins, otherwise the pointer decides.
  logic grant0, grant1, is_clear, cnt_last;
  always_comb begin
    grant0     = (state_q == ST_IDLE) & req0_valid & (~req1_valid | ~ptr_q);
    grant1     = (state_q == ST_IDLE) & req1_valid & (~req0_valid |  ptr_q);
    req0_ready = grant0 & ~reset_reset;
    req1_ready = grant1 & ~reset_reset;
  end

  // Next-state, counter and output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = 1'b0;
`ifdef LCD_ARB_INIT_EN
    init_idx_d = init_idx_q;
`endif
    cnt_last   = (cnt_q == ONE);
    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    is_clear   = ~lcd_rs_q & ((lcd_data_q == 8'h01) | (lcd_data_q == 8'h02) | (lcd_data_q == 8'h03));
    case (state_q)
      ST_IDLE: begin
        if (req0_ready | req1_ready) begin
          lcd_rs_d   = req0_ready ? req0_rs   : req1_rs;
          lcd_data_d = req0_ready ? req0_data : req1_data;
          ptr_d      = req0_ready;
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d  = ST_PULSE;
          cnt_d    = EN_LD;
          lcd_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d    = cnt_q - ONE;
          lcd_en_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_WAIT;
          cnt_d   = is_clear ? CLEAR_LD : WAIT_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_last) begin
`ifdef LCD_ARB_INIT_EN
          if (init_idx_q != INIT_LEN) begin
            state_d = ST_INIT;
            cnt_d   = ONE;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
`ifdef LCD_ARB_INIT_EN
      ST_POR: begin
        if (cnt_last) begin
          state_d = ST_INIT;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_INIT: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_byte(init_idx_q);
        init_idx_d = init_idx_q + 3'd1;
        state_d    = ST_SETUP;
        cnt_d      = SETUP_LD;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered LCD outputs; reset drops lcd_en immediately.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
`ifdef LCD_ARB_INIT_EN
      state_q    <= ST_POR;
      cnt_q      <= POR_LD;
      init_idx_q <= 3'd0;
`else
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
`endif
      ptr_q      <= 1'b0;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
`ifdef LCD_ARB_INIT_EN
      init_idx_q <= init_idx_d;
`endif
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rw   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_arbiter
// Purpose  : Scoreboard bench for lcd_write_arbiter. A timing model predicts
//            ready/busy every cycle and queues each accepted byte; a monitor
//            matches every enable pulse against the queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_write_arbiter;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int W  = 5;
  localparam int CW = 20;
  localparam int P  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v [2];
  logic       rs [2];
  logic [7:0] d [2];
  logic       ready0, ready1, busy, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_write_arbiter #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .WAIT_CYC(W),
    .CLEAR_WAIT_CYC(CW), .POR_CYC(P)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .req0_valid(v[0]), .req0_rs(rs[0]), .req0_data(d[0]), .req0_ready(ready0),
    .req1_valid(v[1]), .req1_rs(rs[1]), .req1_data(d[1]), .req1_ready(ready1),
    .busy(busy), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;   // expected rise cycle, -1 when not timed
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         next_free = 0;
  logic       ptr_m = 1'b0;
  logic       init_phase = 1'b0;
  logic       acc [2];
  logic       in_pulse = 1'b0;
  int         fall_exp = 0;
  logic [8:0] pulse_val = '0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Execution time of a byte from acceptance to the next possible accept.
  function automatic int txn_len(input logic r, input logic [7:0] b);
    int wt;
    wt = (!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? CW : W;
    return 1 + S + E + H + wt;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model and output monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    logic idle, e0, e1;
    exp_t x;
    if (rst) begin
      in_pulse = 1'b0;
    end else begin
      if (init_phase && !busy) begin
        init_phase = 1'b0;
        next_free  = cyc;
      end
      idle = !init_phase && (cyc >= next_free);
      e0 = idle && v[0] && (!v[1] || !ptr_m);
      e1 = idle && v[1] && (!v[0] ||  ptr_m);
      chk("ready0", int'(ready0), int'(e0));
      chk("ready1", int'(ready1), int'(e1));
      chk("busy", int'(busy), int'(!idle));
      chk("rw", int'(lcd_rw), 0);
      if (e0 || e1) begin
        x.rs   = e0 ? rs[0] : rs[1];
        x.data = e0 ? d[0]  : d[1];
        x.rise = cyc + 1 + S;
        sb.push_back(x);
        next_free = cyc + txn_len(x.rs, x.data);
        ptr_m     = e0;
        if (e0) acc[0] = 1'b1; else acc[1] = 1'b1;
      end
      if (lcd_en && !in_pulse) begin
        in_pulse = 1'b1;
        fall_exp = cyc + E;
        pulse_val = {lcd_rs, lcd_data};
        if (sb.size() == 0) begin
          chk("unexpected_en", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("pulse_data", int'(lcd_data), int'(x.data));
          chk("pulse_rs", int'(lcd_rs), int'(x.rs));
          if (x.rise >= 0) chk("en_rise_cycle", cyc, x.rise);
        end
      end else if (!lcd_en && in_pulse) begin
        in_pulse = 1'b0;
        chk("en_fall_cycle", cyc, fall_exp);
        chk("hold_value", int'({lcd_rs, lcd_data}), int'(pulse_val));
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_en", int'(lcd_en), 0);
    sb.delete();
    ptr_m = 1'b0; next_free = 0; acc[0] = 1'b0; acc[1] = 1'b0;
`ifdef LCD_ARB_INIT_EN
    init_phase = 1'b1;
`endif
    v[0] = 1'b1; v[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_ready0", int'(ready0), 0);
    chk("rst_ready1", int'(ready1), 0);
`ifdef LCD_ARB_INIT_EN
    chk("rst_busy", int'(busy), 1);
`else
    chk("rst_busy", int'(busy), 0);
`endif
    v[0] = 1'b0; v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef LCD_ARB_INIT_EN
    begin
      logic [7:0] seq [6];
      exp_t x;
      seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      for (int i = 0; i < 6; i++) begin
        x.rs = 1'b0; x.data = seq[i]; x.rise = -1;
        sb.push_back(x);
      end
      for (int k = 0; k < 1000 && init_phase; k++) @(posedge clk);
      chk("init_done", int'(init_phase), 0);
      chk("init_drained", sb.size(), 0);
    end
`endif
  endtask

  task automatic wait_acc(input int p, input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (acc[p]) break;
    end
    if (!acc[p]) chk(nm, 0, 1);
    acc[p] = 1'b0;
  endtask

  task automatic send(input int p, input logic r, input logic [7:0] b);
    @(posedge clk); #1;
    v[p] = 1'b1; rs[p] = r; d[p] = b;
    wait_acc(p, "send_timeout");
    v[p] = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h03;
      3: return 8'h04;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    v[0] = 1'b0; v[1] = 1'b0; rs[0] = 1'b0; rs[1] = 1'b0; d[0] = '0; d[1] = '0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    apply_reset();

    // Single data write from port 0.
    send(0, 1'b1, 8'h41);

    // Continuous contention with distinct bytes: grants alternate.
    @(posedge clk); #1;
    v[0] = 1'b1; rs[0] = 1'b1; d[0] = 8'h10;
    v[1] = 1'b1; rs[1] = 1'b1; d[1] = 8'h80;
    repeat (80) begin
      @(posedge clk); #1;
      if (acc[0]) begin acc[0] = 1'b0; d[0] = d[0] + 8'd1; end
      if (acc[1]) begin acc[1] = 1'b0; d[1] = d[1] + 8'd1; end
    end
    v[0] = 1'b0; v[1] = 1'b0;

    // Long-wait commands versus ordinary command and data.
    send(1, 1'b0, 8'h01);
    send(1, 1'b0, 8'h04);
    send(0, 1'b0, 8'h02);
    send(1, 1'b0, 8'h03);
    send(0, 1'b1, 8'h01);

    // Port 1 arrives mid-transaction; port 0 drops valid during SETUP.
    @(posedge clk); #1;
    v[0] = 1'b1; rs[0] = 1'b1; d[0] = 8'h55;
    wait_acc(0, "mid_acc0");
    v[0] = 1'b0; d[0] = 8'hAA; rs[1] = 1'b1; d[1] = 8'h66; v[1] = 1'b1;
    wait_acc(1, "mid_acc1");
    v[1] = 1'b0;

    // Randomised traffic, including ignored changes while not granted.
    repeat (600) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          acc[p] = 1'b0;
          v[p] = 1'($urandom_range(0, 1));
          rs[p] = 1'($urandom); d[p] = pick_byte();
        end else if (!v[p]) begin
          if ($urandom_range(0, 3) == 0) begin
            v[p] = 1'b1; rs[p] = 1'($urandom); d[p] = pick_byte();
          end
        end else if ($urandom_range(0, 7) == 0) begin
          v[p] = 1'($urandom); rs[p] = 1'($urandom); d[p] = pick_byte();
        end
      end
    end
    v[0] = 1'b0; v[1] = 1'b0;
    for (int k = 0; k < 200 && (sb.size() != 0 || busy); k++) @(posedge clk);

    // Reset while the enable pulse is high; port 0 was served last.
    @(posedge clk); #1;
    v[0] = 1'b1; rs[0] = 1'b1; d[0] = 8'h5A;
    wait_acc(0, "pre_rst_acc");
    v[0] = 1'b0;
    for (int k = 0; k < 50 && !lcd_en; k++) @(negedge clk);
    chk("pulse_seen", int'(lcd_en), 1);
    @(posedge clk);
    apply_reset();
    @(posedge clk); #1;
    v[0] = 1'b1; rs[0] = 1'b1; d[0] = 8'h31;
    v[1] = 1'b1; rs[1] = 1'b1; d[1] = 8'h32;
    @(negedge clk);
    chk("post_rst_port0_first", int'(ready0), 1);
    wait_acc(0, "post_rst_acc0");
    v[0] = 1'b0;
    wait_acc(1, "post_rst_acc1");
    v[1] = 1'b0;

    for (int k = 0; k < 200 && (sb.size() != 0 || busy); k++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", sb.size(), 0);
    chk("drain_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
